sevenseg_scan_controller: RTL and testbench

Time-multiplexes four 4-bit hex digits onto the single shared `sevenseg_decoder` and the 4-digit common-anode display. It rotates one active-low anode at a time and presents the matching nibble to the decoder's `i_Hex` input. An optional blanking gap between digits suppresses ghosting. Display data is double-buffered and committed only at frame boundaries, so the display never shows a torn value. It sits between the lab top level (switch/ALU results) and the decoder/anode pins.

---
 rtl/sevenseg_scan_controller.sv | 130 +++++++++++++
 tb/tb_sevenseg_scan_controller.sv | 124 ++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_controller.sv
// sevenseg_scan_controller
//   Time-multiplexes four hex nibbles onto one shared seven-segment decoder
//   and a 4-digit common-anode display. It rotates one active-low anode at a
//   time. New display data is staged and committed only at the frame wrap
//   (digit 3 -> 0), so a digit never shows a torn value.
//
//   Optional feature macro: SEVENSEG_SCAN_BLANK_EN
//     When defined, a BLANK gap of BLANK_CYCLES (all anodes off) follows each
//     digit's DIVIDE-cycle dwell. When undefined, digits follow back to back
//     and BLANK_CYCLES only sizes the counter.
//
// Parameters
//   DIVIDE       active dwell per digit in cycles (>= 2)
//   BLANK_CYCLES blank gap per digit in cycles (>= 1)
// Ports
//   i_clk        system clock
//   i_reset      synchronous active-high reset
//   i_data       [3:0] digit 0 (rightmost) .. [15:12] digit 3
//   i_load       stage i_data (sampled every cycle it is high)
//   i_digit_en   per-digit enable, 1 = lit
//   o_hex        nibble for the decoder
//   o_an_n       active-low anodes
//   o_digit      current digit index
//   o_load_ack   one-cycle pulse when the display buffer commits
//   o_frame      one-cycle pulse when the scan wraps 3 -> 0
module sevenseg_scan_controller #(
  parameter int DIVIDE       = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_data,
  input  logic        i_load,
  input  logic [3:0]  i_digit_en,
  output logic [3:0]  o_hex,
  output logic [3:0]  o_an_n,
  output logic [1:0]  o_digit,
  output logic        o_load_ack,
  output logic        o_frame
);

  localparam int CNT_MAX = (DIVIDE > BLANK_CYCLES) ? DIVIDE : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] DIV_TC = CW'(DIVIDE - 1);
`ifdef SEVENSEG_SCAN_BLANK_EN
  localparam logic [CW-1:0] BLK_TC = CW'(BLANK_CYCLES - 1);
`endif

  localparam logic [0:0] ST_ACTIVE = 1'b0;
`ifdef SEVENSEG_SCAN_BLANK_EN
  localparam logic [0:0] ST_BLANK  = 1'b1;
`endif

  logic [15:0]   disp, disp_nxt;
  logic [15:0]   stage, stage_nxt;
  logic          pend, pend_nxt;
  logic [0:0]    state, state_nxt;
  logic [1:0]    digit, digit_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          step, wrap, commit;
  logic [3:0]    an_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    step      = 1'b0;
`ifdef SEVENSEG_SCAN_BLANK_EN
    if (state == ST_BLANK) begin
      if (cnt == BLK_TC) begin
        cnt_nxt   = '0;
        state_nxt = ST_ACTIVE;
        step      = 1'b1;
      end
    end else if (cnt == DIV_TC) begin
      cnt_nxt   = '0;
      state_nxt = ST_BLANK;
    end
`else
    if (cnt == DIV_TC) begin
      cnt_nxt = '0;
      step    = 1'b1;
    end
`endif
    digit_nxt = step ? digit + 2'd1 : digit;
    wrap      = step && (digit == 2'd3);

    // A load on the wrap cycle itself is taken directly, bypassing stage.
    commit    = wrap && (pend || i_load);
    disp_nxt  = commit ? (i_load ? i_data : stage) : disp;
    stage_nxt = i_load ? i_data : stage;
    pend_nxt  = commit ? 1'b0 : (pend || i_load);

    // Disabled digits still occupy their slot; only the anode is held off.
    an_nxt = 4'hF;
    for (int k = 0; k < 4; k++)
      if (state_nxt == ST_ACTIVE && digit_nxt == 2'(k) && i_digit_en[k])
        an_nxt[k] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      disp       <= '0;
      stage      <= '0;
      pend       <= 1'b0;
      state      <= ST_ACTIVE;
      digit      <= 2'd0;
      cnt        <= '0;
      o_hex      <= 4'h0;
      o_an_n     <= 4'hF;
      o_digit    <= 2'd0;
      o_load_ack <= 1'b0;
      o_frame    <= 1'b0;
    end else begin
      disp       <= disp_nxt;
      stage      <= stage_nxt;
      pend       <= pend_nxt;
      state      <= state_nxt;
      digit      <= digit_nxt;
      cnt        <= cnt_nxt;
      // Outputs come from next-state values so they line up with the state.
      o_hex      <= disp_nxt[{digit_nxt, 2'b00} +: 4];
      o_an_n     <= an_nxt;
      o_digit    <= digit_nxt;
      o_load_ack <= commit;
      o_frame    <= wrap;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_controller.sv
module tb_sevenseg_scan_controller;

  localparam int D = 4;
`ifdef SEVENSEG_SCAN_BLANK_EN
  localparam int B = 2;
`else
  localparam int B = 0;
`endif
  localparam int P = D + B;     // slot per digit
  localparam int F = 4 * P;     // frame period

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic        load;
  logic [3:0]  en;
  logic [3:0]  hex;
  logic [3:0]  an_n;
  logic [1:0]  dig;
  logic        ack;
  logic        frame;

  int total = 0;
  int bad   = 0;

  sevenseg_scan_controller #(.DIVIDE(D), .BLANK_CYCLES(2)) dut (
    .i_clk(clk), .i_reset(rst), .i_data(data), .i_load(load),
    .i_digit_en(en), .o_hex(hex), .o_an_n(an_n), .o_digit(dig),
    .o_load_ack(ack), .o_frame(frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int n, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d got=%h want=%h", tag, n, obs, exp);
    end
  endtask

  // Advance one edge (n = edges since reset release) and check all outputs
  // against the scan position derived from n.
  task automatic step_chk(input int n, input logic [15:0] shown,
                          input logic exp_ack, input logic [3:0] exp_en);
    int t, d;
    logic [3:0] ea;
    @(posedge clk);
    @(negedge clk);
    t  = n % F;
    d  = t / P;
    ea = 4'hF;
    if ((t % P) < D && exp_en[d]) ea[d] = 1'b0;
    chk("an_n",  n, {12'h0, an_n},  {12'h0, ea});
    chk("digit", n, {14'h0, dig},   16'(d));
    chk("hex",   n, {12'h0, hex},   {12'h0, shown[4*d +: 4]});
    chk("frame", n, {15'h0, frame}, {15'h0, (t == 0)});
    chk("ack",   n, {15'h0, ack},   {15'h0, exp_ack});
  endtask

  task automatic rst_chk(input int n);
    @(posedge clk);
    @(negedge clk);
    chk("rst_an_n",  n, {12'h0, an_n},  16'h000F);
    chk("rst_hex",   n, {12'h0, hex},   16'h0000);
    chk("rst_digit", n, {14'h0, dig},   16'h0000);
    chk("rst_ack",   n, {15'h0, ack},   16'h0000);
    chk("rst_frame", n, {15'h0, frame}, 16'h0000);
  endtask

  initial begin
    logic [15:0] shown;
    logic        eack;
    logic [3:0]  een;
    int          n0;

    // Reset for 3 cycles with a load request that must be ignored.
    rst  = 1'b1;
    load = 1'b1;
    data = 16'hFFFF;
    en   = 4'b1111;
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst_chk(i);

    // Release; load 4321 on the first cycle after reset.
    rst  = 1'b0;
    data = 16'h4321;

    // Frames 1..5: first frame blank data, commit 4321 at F, no commit at
    // 2F, AAAA then BBBB staged -> one commit at 3F, partial enable in
    // frame 5.
    for (int n = 1; n <= 5 * F; n++) begin
      shown = (n < F) ? 16'h0000 : (n < 3 * F) ? 16'h4321 : 16'hBBBB;
      eack  = (n == F) || (n == 3 * F);
      een   = (n > 4 * F) ? 4'b0101 : 4'b1111;
      step_chk(n, shown, eack, een);
      load = 1'b0;
      if (n == 2 * F + 2) begin load = 1'b1; data = 16'hAAAA; end
      if (n == 2 * F + 4) begin load = 1'b1; data = 16'hBBBB; end
      if (n == 4 * F) en = 4'b0101;
    end

    // Frame 6: stage CCCC, then reset in digit 2's gap (or mid-dwell when
    // there is no gap) with the load still pending.
    en = 4'b1111;
    n0 = 5 * F + 2 * P + ((B > 0) ? D : 1);
    for (int n = 5 * F + 1; n <= n0; n++) begin
      step_chk(n, 16'hBBBB, 1'b0, 4'b1111);
      load = (n == 5 * F + 1);
      if (load) data = 16'hCCCC;
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) rst_chk(n0 + 1 + i);
    rst = 1'b0;

    // After release: buffer cleared, pending load dropped, no ack at wrap.
    for (int m = 1; m <= F + 2; m++) step_chk(m, 16'h0000, 1'b0, 4'b1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
